// File: rtl/ecc_scalar_mult_if.sv
// Bundle for the scalar multiplier: the request/result handshake and the
// hook-up to the external combinational point doubler.
interface ecc_scalar_mult_if #(
  parameter int W  = 4,
  parameter int KW = 4
);
  logic          start;
  logic [KW-1:0] k;
  logic [W-1:0]  px;
  logic [W-1:0]  py;
  logic          busy;
  logic          done;
  logic [W-1:0]  rx;
  logic [W-1:0]  ry;
  logic          r_inf;
  logic [W-1:0]  dbl_x;
  logic [W-1:0]  dbl_y;
  logic [W-1:0]  dbl_rx;
  logic [W-1:0]  dbl_ry;

  // master: requester that also hosts the doubler; slave: the multiplier
  modport master (
    output start, k, px, py, dbl_rx, dbl_ry,
    input  busy, done, rx, ry, r_inf, dbl_x, dbl_y
  );

  modport slave (
    input  start, k, px, py, dbl_rx, dbl_ry,
    output busy, done, rx, ry, r_inf, dbl_x, dbl_y
  );
endinterface

// File: rtl/ecc_scalar_mult.sv
// MSB-first double-and-add scalar multiplier R = k*P over GF(P), curve a = 1.
// Doubling is external (combinational); addition uses a Fermat inverse.
module ecc_scalar_mult #(
  parameter int P    = 11,
  parameter int W    = 4,
  parameter int KW   = 4,
  parameter int EXPW = 4
) (
  input  logic             clk,
  input  logic             rst,
  ecc_scalar_mult_if.slave bus
);

  localparam int IW = (KW > 1) ? $clog2(KW) : 1;
  localparam int JW = (EXPW > 1) ? $clog2(EXPW) : 1;
  localparam logic [EXPW-1:0] EXP = EXPW'(P - 2);

  typedef enum logic [2:0] {IDLE, DBL, ADD_CHK, INV, ADD_FIN, DONE} state_t;

  function automatic logic [W-1:0] mul_mod(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] prod;
    prod = (2*W)'(a) * (2*W)'(b);
    return W'(prod % (2*W)'(P));
  endfunction

  // a + P - b keeps the intermediate non-negative before reduction
  function automatic logic [W-1:0] sub_mod(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = (W+1)'(a) + (W+1)'(P) - (W+1)'(b);
    return W'(s % (W+1)'(P));
  endfunction

  state_t        state_reg, state_next;
  logic [KW-1:0] k_reg, k_next;
  logic [W-1:0]  px_reg, px_next, py_reg, py_next;
  logic [W-1:0]  r_x_reg, r_x_next, r_y_reg, r_y_next;
  logic          r_inf_reg, r_inf_next;
  logic [IW-1:0] idx_reg, idx_next;
  logic          dbl_add_reg, dbl_add_next;
  logic [W-1:0]  d_reg, d_next, num_reg, num_next, acc_reg, acc_next;
  logic [JW-1:0] j_reg, j_next;
  logic [W-1:0]  rx_reg, rx_next, ry_reg, ry_next;
  logic          rinf_out_reg, rinf_out_next;
  logic          busy_reg, busy_next;

  logic [EXPW-1:0] exp_rev;
  logic [W-1:0]    sq, sq_d, lam, x3, y3;
  logic            advance, last_bit;

  // exponent bits in consumption order, so INV cycle j reads exp_rev[j]
  for (genvar gi = 0; gi < EXPW; gi++) begin : g_exp
    assign exp_rev[gi] = EXP[EXPW-1-gi];
  end

  assign sq       = mul_mod(acc_reg, acc_reg);
  assign sq_d     = mul_mod(sq, d_reg);
  assign lam      = mul_mod(num_reg, acc_reg);
  assign x3       = sub_mod(sub_mod(mul_mod(lam, lam), r_x_reg), px_reg);
  assign y3       = sub_mod(mul_mod(lam, sub_mod(r_x_reg, x3)), r_y_reg);
  assign last_bit = (idx_reg == '0);

  always_comb begin
    state_next    = state_reg;
    k_next        = k_reg;
    px_next       = px_reg;
    py_next       = py_reg;
    r_x_next      = r_x_reg;
    r_y_next      = r_y_reg;
    r_inf_next    = r_inf_reg;
    idx_next      = idx_reg;
    dbl_add_next  = dbl_add_reg;
    d_next        = d_reg;
    num_next      = num_reg;
    acc_next      = acc_reg;
    j_next        = j_reg;
    rx_next       = rx_reg;
    ry_next       = ry_reg;
    rinf_out_next = rinf_out_reg;
    busy_next     = busy_reg;
    advance       = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          k_next       = bus.k;
          px_next      = bus.px;
          py_next      = bus.py;
          r_x_next     = '0;
          r_y_next     = '0;
          r_inf_next   = 1'b1;
          idx_next     = IW'(KW - 1);
          dbl_add_next = 1'b0;
          busy_next    = 1'b1;
          state_next   = DBL;
        end
      end
      DBL: begin
        if (r_inf_reg || r_y_reg == '0) begin
          r_x_next   = '0;
          r_y_next   = '0;
          r_inf_next = 1'b1;
        end else begin
          r_x_next = bus.dbl_rx;
          r_y_next = bus.dbl_ry;
        end
        // the R = Pbase case borrows this state and skips the add check
        if (dbl_add_reg) begin
          dbl_add_next = 1'b0;
          advance      = 1'b1;
        end else if (k_reg[idx_reg]) begin
          state_next = ADD_CHK;
        end else begin
          advance = 1'b1;
        end
      end
      ADD_CHK: begin
        if (r_inf_reg) begin
          r_x_next   = px_reg;
          r_y_next   = py_reg;
          r_inf_next = 1'b0;
          advance    = 1'b1;
        end else if (r_x_reg == px_reg && r_y_reg != py_reg) begin
          r_x_next   = '0;
          r_y_next   = '0;
          r_inf_next = 1'b1;
          advance    = 1'b1;
        end else if (r_x_reg == px_reg) begin
          dbl_add_next = 1'b1;
          state_next   = DBL;
        end else begin
          d_next     = sub_mod(px_reg, r_x_reg);
          num_next   = sub_mod(py_reg, r_y_reg);
          acc_next   = W'(1);
          j_next     = '0;
          state_next = INV;
        end
      end
      INV: begin
        acc_next = exp_rev[j_reg] ? sq_d : sq;
        j_next   = j_reg + JW'(1);
        if (j_reg == JW'(EXPW - 1)) begin
          state_next = ADD_FIN;
        end
      end
      ADD_FIN: begin
        r_x_next = x3;
        r_y_next = y3;
        advance  = 1'b1;
      end
      DONE: begin
        busy_next  = 1'b0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    if (advance) begin
      if (last_bit) begin
        state_next = DONE;
      end else begin
        idx_next   = idx_reg - IW'(1);
        state_next = DBL;
      end
    end

    // publish the final R as DONE is entered, so it is valid alongside done
    if (state_next == DONE) begin
      rx_next       = r_x_next;
      ry_next       = r_y_next;
      rinf_out_next = r_inf_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      k_reg        <= '0;
      px_reg       <= '0;
      py_reg       <= '0;
      r_x_reg      <= '0;
      r_y_reg      <= '0;
      r_inf_reg    <= 1'b0;
      idx_reg      <= '0;
      dbl_add_reg  <= 1'b0;
      d_reg        <= '0;
      num_reg      <= '0;
      acc_reg      <= '0;
      j_reg        <= '0;
      rx_reg       <= '0;
      ry_reg       <= '0;
      rinf_out_reg <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      k_reg        <= k_next;
      px_reg       <= px_next;
      py_reg       <= py_next;
      r_x_reg      <= r_x_next;
      r_y_reg      <= r_y_next;
      r_inf_reg    <= r_inf_next;
      idx_reg      <= idx_next;
      dbl_add_reg  <= dbl_add_next;
      d_reg        <= d_next;
      num_reg      <= num_next;
      acc_reg      <= acc_next;
      j_reg        <= j_next;
      rx_reg       <= rx_next;
      ry_reg       <= ry_next;
      rinf_out_reg <= rinf_out_next;
      busy_reg     <= busy_next;
    end
  end

  assign bus.busy  = busy_reg;
  assign bus.done  = (state_reg == DONE);
  assign bus.rx    = rx_reg;
  assign bus.ry    = ry_reg;
  assign bus.r_inf = rinf_out_reg;
  assign bus.dbl_x = r_x_reg;
  assign bus.dbl_y = r_y_reg;

endmodule

// File: tb/tb_ecc_scalar_mult.sv
// Bench for ecc_scalar_mult on y^2 = x^3 + x + 6 mod 11: directed and random
// scalars against a point-arithmetic reference model.
module tb_ecc_scalar_mult;

  typedef struct packed {
    bit inf;
    int x;
    int y;
  } pt_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   passes = 0;
  int   cyc;
  bit   got;
  int   pts_x[$];
  int   pts_y[$];

  always #5 clk = ~clk;

  ecc_scalar_mult_if #(.W(4), .KW(4)) bus ();

  ecc_scalar_mult #(.P(11), .W(4), .KW(4), .EXPW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic int md(input int v);
    return ((v % 11) + 11) % 11;
  endfunction

  function automatic int inv(input int v);
    for (int i = 1; i < 11; i++) if (md(v * i) == 1) return i;
    return 0;
  endfunction

  function automatic pt_t mkpt(input int x, input int y);
    pt_t p;
    p.inf = 1'b0;
    p.x   = x;
    p.y   = y;
    return p;
  endfunction

  function automatic pt_t pt_inf();
    pt_t p;
    p.inf = 1'b1;
    p.x   = 0;
    p.y   = 0;
    return p;
  endfunction

  // textbook affine group law, including doubling and inverse points
  function automatic pt_t pt_add(input pt_t a, input pt_t b);
    int lam, x3;
    if (a.inf) return b;
    if (b.inf) return a;
    if (a.x == b.x) begin
      if (md(a.y + b.y) == 0) return pt_inf();
      lam = md((3 * a.x * a.x + 1) * inv(md(2 * a.y)));
    end else begin
      lam = md((b.y - a.y) * inv(md(b.x - a.x)));
    end
    x3 = md(lam * lam - a.x - b.x);
    return mkpt(x3, md(lam * (a.x - x3) - a.y));
  endfunction

  function automatic pt_t ref_mult(input int kk, input pt_t p);
    pt_t r;
    r = pt_inf();
    for (int i = 0; i < kk; i++) r = pt_add(r, p);
    return r;
  endfunction

  function automatic int ref_latency(input int kk, input pt_t p);
    pt_t r;
    int  lat;
    r   = pt_inf();
    lat = 1;
    for (int i = 3; i >= 0; i--) begin
      lat += 1;
      r = pt_add(r, r);
      if (((kk >> i) & 1) == 1) begin
        lat += 1;
        if (r.inf || r.x == p.x) begin
          if (!r.inf && r.y == p.y) lat += 1;
        end else begin
          lat += 5;
        end
        r = pt_add(r, p);
      end
    end
    return lat + 1;
  endfunction

  // y = 0 / O inputs get a deliberately wrong image, so a DUT that consumes it
  // produces a visibly wrong result
  always_comb begin
    pt_t a;
    pt_t r;
    a = mkpt(int'(bus.dbl_x), int'(bus.dbl_y));
    if (bus.dbl_y == '0) r = mkpt(0, 0);
    else r = pt_add(a, a);
    bus.dbl_rx = 4'(r.x);
    bus.dbl_ry = 4'(r.y);
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic do_mult(input int kk, input int xx, input int yy, input bit spam);
    pt_t exp_pt;
    int  exp_lat;
    exp_pt  = ref_mult(kk, mkpt(xx, yy));
    exp_lat = ref_latency(kk, mkpt(xx, yy));
    @(negedge clk);
    bus.start = 1'b1;
    bus.k     = 4'(kk);
    bus.px    = 4'(xx);
    bus.py    = 4'(yy);
    cyc       = 1;
    got       = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    bus.start = 1'b0;
    check("busy_after_start", int'(bus.busy), 1);
    while (!got && cyc < 300) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.done) begin
        got = 1'b1;
        bus.start = 1'b0;
      end else begin
        bus.start = spam && (cyc % 3 == 0);
        bus.k     = spam ? 4'(~kk) : 4'(kk);
      end
    end
    bus.start = 1'b0;
    check("done_seen", int'(got), 1);
    if (got) begin
      check("r_inf", int'(bus.r_inf), int'(exp_pt.inf));
      check("rx", int'(bus.rx), exp_pt.x);
      check("ry", int'(bus.ry), exp_pt.y);
      check("latency", cyc, exp_lat);
      @(posedge clk);
      #1;
      check("done_pulse_1cyc", int'(bus.done), 0);
      check("busy_after_done", int'(bus.busy), 0);
      check("rx_held", int'(bus.rx), exp_pt.x);
    end
    $display("k=%0d P=(%0d,%0d) -> rx=%0d ry=%0d r_inf=%0d latency=%0d (exp %0d,%0d,%0d lat %0d)",
             kk, xx, yy, bus.rx, bus.ry, bus.r_inf, cyc, exp_pt.x, exp_pt.y, exp_pt.inf, exp_lat);
  endtask

  initial begin
    int ix;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.k     = '0;
    bus.px    = '0;
    bus.py    = '0;

    for (int x = 0; x < 11; x++)
      for (int y = 0; y < 11; y++)
        if (md(y * y - x * x * x - x - 6) == 0) begin
          pts_x.push_back(x);
          pts_y.push_back(y);
        end

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_r_inf", int'(bus.r_inf), 0);
    check("rst_rx", int'(bus.rx), 0);
    check("rst_ry", int'(bus.ry), 0);
    check("rst_dbl_x", int'(bus.dbl_x), 0);
    check("rst_dbl_y", int'(bus.dbl_y), 0);
    @(negedge clk);
    rst = 1'b0;

    do_mult(0, 2, 7, 1'b0);
    do_mult(1, 2, 7, 1'b0);
    do_mult(2, 2, 7, 1'b0);
    do_mult(3, 2, 7, 1'b0);
    do_mult(12, 2, 7, 1'b0);
    do_mult(13, 2, 7, 1'b0);
    do_mult(5, 2, 7, 1'b1);

    // abort in the middle of the inversion for k = 3
    @(negedge clk);
    bus.start = 1'b1;
    bus.k     = 4'd3;
    bus.px    = 4'd2;
    bus.py    = 4'd7;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy", int'(bus.busy), 0);
    check("abort_done", int'(bus.done), 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("abort_no_done", int'(bus.done), 0);
    end
    $display("reset mid-INV: busy=%0d done=%0d", bus.busy, bus.done);
    @(negedge clk);
    rst = 1'b0;
    do_mult(3, 2, 7, 1'b0);

    for (int n = 0; n < 20; n++) begin
      ix = int'($urandom_range(0, pts_x.size() - 1));
      do_mult(int'($urandom_range(0, 15)), pts_x[ix], pts_y[ix], n[0]);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
